l2_arbiter: RTL and testbench

- N-port successor of the single D/I L2 adapter; arbitrates NUM_PORTS L1 requesters (port 0 = dcache, port 1 = icache, further ports = DMA/TLB walker) onto one L2 burst interface.
- Per-port pending latch captures single-cycle request pulses that lose arbitration.
- Grant is held for the whole burst. Beats are counted down against the latched burst size.

---
 rtl/l2_arb_pkg.sv | 15 +
 rtl/l2_arb_pick.sv | 33 +++
 rtl/l2_arbiter.sv | 155 +++++++++++++++
 tb/tb_l2_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the N-port L2 arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // A zero burst size still moves one beat on the L2 side.
    function automatic int unsigned min_one_beat(input int unsigned size);
        return (size == 0) ? 32'd1 : size;
    endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational requester picker: first candidate found searching upward from ptr, wrapping.
// With ptr tied to zero this is plain lowest-index-first priority.
module l2_arb_pick
    import l2_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 3
) (
    input  logic [NUM_PORTS-1:0] cand,
    input  logic [ID_W-1:0]      ptr,
    output logic                 valid,
    output logic [ID_W-1:0]      idx
);

    logic [NUM_PORTS-1:0] rot;

    // Rotate so bit 0 is the port the search starts from.
    assign rot = NUM_PORTS'({cand, cand} >> ptr);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        // Scan far-to-near; the last hit (closest to ptr) wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates NUM_PORTS L1 requesters onto a single L2 burst interface, holding grant per burst.
// Define L2_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 5,
    parameter int ID_W      = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         req_rreq,
    input  logic [NUM_PORTS-1:0]         req_wreq,
    input  logic [NUM_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS*BURST_W-1:0] req_burst_size,
    input  logic [NUM_PORTS*DATA_W-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]         req_busy,
    output logic                         l2_rreq,
    output logic                         l2_wreq,
    output logic [ADDR_W-1:0]            l2_addr,
    output logic [BURST_W-1:0]           l2_burst_size,
    output logic [DATA_W-1:0]            l2_wdata,
    input  logic                         l2_busy,
    output logic [ID_W-1:0]              grant_id
);

    arb_state_e           state, state_nxt;
    logic [NUM_PORTS-1:0] pend_r, pend_w, live, cand, capture;
    logic [ADDR_W-1:0]    pend_addr [NUM_PORTS];
    logic [BURST_W-1:0]   pend_size [NUM_PORTS];
    logic [BURST_W-1:0]   beat_cnt;
    logic [ID_W-1:0]      rr_ptr, pick_idx;
    logic                 pick_valid, grant_load, burst_done, beat;
    logic [ADDR_W-1:0]    win_addr;
    logic [BURST_W-1:0]   win_size;
    logic                 win_rd;

    assign live = req_rreq | req_wreq;
    assign cand = live | pend_r | pend_w;
    assign beat = (state == ST_WAIT) && !l2_busy;

    l2_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_pick (
        .cand  (cand),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        win_addr = '0;
        win_size = '0;
        win_rd   = 1'b0;
        l2_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_idx == ID_W'(i)) begin
                win_addr = live[i] ? req_addr[i*ADDR_W +: ADDR_W] : pend_addr[i];
                win_size = live[i] ? req_burst_size[i*BURST_W +: BURST_W] : pend_size[i];
                win_rd   = req_rreq[i] | pend_r[i];
            end
            if (grant_id == ID_W'(i))
                l2_wdata = req_wdata[i*DATA_W +: DATA_W];
            req_busy[i] = (state == ST_WAIT && grant_id == ID_W'(i)) ? l2_busy : 1'b1;
            // Losers of this cycle (or anyone outside IDLE) park their request once.
            capture[i]  = live[i] && !(pend_r[i] || pend_w[i]) &&
                          ((state != ST_IDLE) || (pick_idx != ID_W'(i)));
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        burst_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_load = 1'b1;
                    state_nxt  = ST_DELAY;
                end
            end
            ST_DELAY: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (beat && beat_cnt == BURST_W'(1)) begin
                    burst_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l2_rreq       <= 1'b0;
            l2_wreq       <= 1'b0;
            grant_id      <= '0;
            l2_addr       <= '0;
            l2_burst_size <= '0;
            beat_cnt      <= '0;
            pend_r        <= '0;
            pend_w        <= '0;
        end else begin
            l2_rreq <= grant_load & win_rd;
            l2_wreq <= grant_load & ~win_rd;
            if (grant_load) begin
                grant_id      <= pick_idx;
                l2_addr       <= win_addr;
                l2_burst_size <= win_size;
                beat_cnt      <= BURST_W'(min_one_beat(32'(win_size)));
            end else if (beat) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (state == ST_WAIT && grant_id == ID_W'(i)) begin
                    pend_r[i] <= 1'b0;
                    pend_w[i] <= 1'b0;
                end else if (capture[i]) begin
                    pend_r[i] <= req_rreq[i];
                    pend_w[i] <= ~req_rreq[i];
                end
            end
        end
    end

    // NOTE: parked addr/size are only read behind a set flag, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (capture[i]) begin
                pend_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                pend_size[i] <= req_burst_size[i*BURST_W +: BURST_W];
            end
        end
    end

`ifdef L2_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (burst_done)
            rr_ptr <= (grant_id == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules.
module tb_l2_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 5;
    localparam int IW = 2;
`ifdef L2_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP-1:0]    req_rreq, req_wreq, req_busy;
    logic [NP*AW-1:0] req_addr;
    logic [NP*BW-1:0] req_burst_size;
    logic [NP*DW-1:0] req_wdata;
    logic             l2_rreq, l2_wreq, l2_busy;
    logic [AW-1:0]    l2_addr;
    logic [BW-1:0]    l2_burst_size;
    logic [DW-1:0]    l2_wdata;
    logic [IW-1:0]    grant_id;

    always #5 clk = ~clk;

    l2_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_W   (BW),
        .ID_W      (IW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_rreq       (req_rreq),
        .req_wreq       (req_wreq),
        .req_addr       (req_addr),
        .req_burst_size (req_burst_size),
        .req_wdata      (req_wdata),
        .req_busy       (req_busy),
        .l2_rreq        (l2_rreq),
        .l2_wreq        (l2_wreq),
        .l2_addr        (l2_addr),
        .l2_burst_size  (l2_burst_size),
        .l2_wdata       (l2_wdata),
        .l2_busy        (l2_busy),
        .grant_id       (grant_id)
    );

    // Reference model: outstanding request per port, current owner and remaining beats.
    typedef struct {
        bit            valid;
        bit            rd;
        logic [AW-1:0] addr;
        logic [BW-1:0] size;
    } req_t;

    req_t          outst [NP];
    int            m_owner;
    bit            m_delay;
    int            m_beats;
    int            m_ptr;
    logic          e_rreq, e_wreq;
    logic [IW-1:0] e_grant;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_size;

    int tests = 0;
    int fails = 0;

    function automatic bit can_req(input int p);
        return !outst[p].valid && m_owner != p;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) outst[p] = '{1'b0, 1'b0, '0, '0};
        m_owner = -1;
        m_delay = 1'b0;
        m_beats = 0;
        m_ptr   = 0;
        e_rreq  = 1'b0;
        e_wreq  = 1'b0;
        e_grant = '0;
        e_addr  = '0;
        e_size  = '0;
    endtask

    task automatic set_req(input int p, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [BW-1:0] s);
        req_rreq[p] = r;
        req_wreq[p] = w;
        req_addr[p*AW +: AW] = a;
        req_burst_size[p*BW +: BW] = s;
    endtask

    task automatic model_update();
        int w;
        for (int p = 0; p < NP; p++)
            if ((req_rreq[p] || req_wreq[p]) && !outst[p].valid)
                outst[p] = '{1'b1, req_rreq[p], req_addr[p*AW +: AW], req_burst_size[p*BW +: BW]};
        e_rreq = 1'b0;
        e_wreq = 1'b0;
        if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = RR ? (m_ptr + k) % NP : k;
                if (w < 0 && outst[p].valid) w = p;
            end
            if (w >= 0) begin
                e_grant = IW'(w);
                e_addr  = outst[w].addr;
                e_size  = outst[w].size;
                e_rreq  = outst[w].rd;
                e_wreq  = !outst[w].rd;
                m_owner = w;
                m_delay = 1'b1;
                m_beats = (outst[w].size == 0) ? 1 : int'(outst[w].size);
                outst[w].valid = 1'b0;
            end
        end else if (m_delay) begin
            m_delay = 1'b0;
        end else if (!l2_busy) begin
            m_beats--;
            if (m_beats == 0) begin
                m_ptr   = (m_owner + 1) % NP;
                m_owner = -1;
            end
        end
    endtask

    // One clock: randomize idle data, check combinational outputs, advance model, check registers.
    task automatic step();
        logic [NP-1:0] exp_busy;
        logic [DW-1:0] exp_wdata;
        for (int p = 0; p < NP; p++) begin
            if (!(req_rreq[p] || req_wreq[p])) begin
                req_addr[p*AW +: AW] = $urandom;
                req_burst_size[p*BW +: BW] = BW'($urandom);
            end
            req_wdata[p*DW +: DW] = $urandom;
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++)
            exp_busy[p] = (m_owner == p && !m_delay) ? l2_busy : 1'b1;
        exp_wdata = req_wdata[e_grant*DW +: DW];
        tests++;
        if (req_busy !== exp_busy) begin
            fails++;
            $display("FAIL req_busy t=%0t got %b exp %b", $time, req_busy, exp_busy);
        end
        tests++;
        if (l2_wdata !== exp_wdata) begin
            fails++;
            $display("FAIL l2_wdata t=%0t got %h exp %h", $time, l2_wdata, exp_wdata);
        end
        model_update();
        @(posedge clk);
        #1;
        tests++;
        if ({l2_rreq, l2_wreq} !== {e_rreq, e_wreq}) begin
            fails++;
            $display("FAIL l2_req t=%0t got r%b w%b exp r%b w%b", $time, l2_rreq, l2_wreq, e_rreq, e_wreq);
        end
        tests++;
        if (grant_id !== e_grant) begin
            fails++;
            $display("FAIL grant_id t=%0t got %0d exp %0d", $time, grant_id, e_grant);
        end
        tests++;
        if ({l2_addr, l2_burst_size} !== {e_addr, e_size}) begin
            fails++;
            $display("FAIL l2_addr_size t=%0t got %h/%0d exp %h/%0d", $time, l2_addr, l2_burst_size, e_addr, e_size);
        end
        req_rreq = '0;
        req_wreq = '0;
    endtask

    task automatic drain();
        l2_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bit any;
            any = (m_owner >= 0);
            for (int p = 0; p < NP; p++) any |= outst[p].valid;
            if (!any) break;
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        tests++;
        if ({l2_rreq, l2_wreq, grant_id, l2_addr, l2_burst_size} !== '0) begin
            fails++;
            $display("FAIL %s_regs got r%b w%b g%0d a%h s%0d exp all zero", tag,
                     l2_rreq, l2_wreq, grant_id, l2_addr, l2_burst_size);
        end
        tests++;
        if (req_busy !== '1) begin
            fails++;
            $display("FAIL %s_busy got %b exp %b", tag, req_busy, {NP{1'b1}});
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_read();
        int pulses = 0, beats0 = 0, beats1 = 0;
        l2_busy = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) set_req(1, 1'b1, 1'b0, 32'h1000_0040, 5'd8);
            step();
            if (l2_rreq === 1'b1) pulses++;
            if (req_busy[1] === 1'b0) beats1++;
            if (req_busy[0] === 1'b0) beats0++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL single_pulses got %0d exp 1", pulses);
        end
        tests++;
        if (beats1 !== 8) begin
            fails++;
            $display("FAIL single_beats got %0d exp 8", beats1);
        end
        tests++;
        if (beats0 !== 0) begin
            fails++;
            $display("FAIL single_port0_busy got %0d low cycles exp 0", beats0);
        end
    endtask

    task automatic test_simultaneous();
        int first_at = -1, second_at = -1;
        l2_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                set_req(0, 1'b1, 1'b0, 32'h100, 5'd4);
                set_req(1, 1'b1, 1'b0, 32'h200, 5'd4);
            end
            step();
            if (l2_rreq === 1'b1) begin
                if (first_at < 0) first_at = i;
                else if (second_at < 0) begin
                    second_at = i;
                    tests++;
                    if (l2_addr !== 32'h200 || grant_id !== 2'd1) begin
                        fails++;
                        $display("FAIL simul_second got a%h g%0d exp a200 g1", l2_addr, grant_id);
                    end
                end
            end
        end
        // DELAY (1) + 4 beats + one IDLE pick cycle.
        tests++;
        if (second_at - first_at !== 6) begin
            fails++;
            $display("FAIL simul_gap got %0d exp 6", second_at - first_at);
        end
    endtask

    task automatic test_pending_write();
        int wreq_at = -1;
        for (int i = 0; i < 24; i++) begin
            l2_busy = (i >= 2 && i < 12) ? ((i % 2) == 0) : 1'b0;
            if (i == 0) set_req(0, 1'b1, 1'b0, 32'h300, 5'd3);
            if (i == 3) set_req(1, 1'b0, 1'b1, 32'h400, 5'd2);
            step();
            if (l2_wreq === 1'b1 && wreq_at < 0) begin
                wreq_at = i;
                tests++;
                if (l2_addr !== 32'h400 || l2_burst_size !== 5'd2 || grant_id !== 2'd1) begin
                    fails++;
                    $display("FAIL pend_write got a%h s%0d g%0d exp a400 s2 g1", l2_addr, l2_burst_size, grant_id);
                end
            end
        end
        // Three beats on alternating busy cycles keep port 0 in WAIT for cycles 2..7.
        tests++;
        if (wreq_at !== 8) begin
            fails++;
            $display("FAIL pend_write_time got %0d exp 8", wreq_at);
        end
    endtask

    task automatic test_zero_size();
        int beats0 = 0;
        l2_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_req(0, 1'b1, 1'b0, 32'h500, 5'd0);
            step();
            if (req_busy[0] === 1'b0) beats0++;
        end
        tests++;
        if (beats0 !== 1) begin
            fails++;
            $display("FAIL zero_size_beats got %0d exp 1", beats0);
        end
    endtask

    task automatic test_arbitration_order();
        int dut_g[$];
        l2_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < NP; p++)
                if (can_req(p)) set_req(p, 1'b1, 1'b0, $urandom, BW'($urandom_range(1, 3)));
            step();
            if (l2_rreq === 1'b1) dut_g.push_back(int'(grant_id));
        end
        tests++;
        if (dut_g.size() < 6) begin
            fails++;
            $display("FAIL order_count got %0d exp >=6", dut_g.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                int exp_g;
                exp_g = RR ? k % NP : 0;
                tests++;
                if (dut_g[k] !== exp_g) begin
                    fails++;
                    $display("FAIL order_%0d got %0d exp %0d", k, dut_g[k], exp_g);
                end
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            l2_busy = ($urandom_range(0, 9) < 3);
            for (int p = 0; p < NP; p++) begin
                if (can_req(p) && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       set_req(p, 1'b1, 1'b0, $urandom, BW'($urandom_range(0, 7)));
                        1:       set_req(p, 1'b0, 1'b1, $urandom, BW'($urandom_range(0, 7)));
                        default: set_req(p, 1'b1, 1'b1, $urandom, BW'($urandom_range(0, 7)));
                    endcase
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_reset_midburst();
        int pulses = 0;
        l2_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_req(0, 1'b1, 1'b0, 32'h600, 5'd10);
            if (i == 3) set_req(1, 1'b1, 1'b0, 32'h700, 5'd2);
            step();
        end
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("midburst_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (l2_rreq === 1'b1 || l2_wreq === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL midburst_pending got %0d pulses exp 0", pulses);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        req_rreq       = '0;
        req_wreq       = '0;
        req_addr       = '0;
        req_burst_size = '0;
        req_wdata      = '0;
        l2_busy        = 1'b0;
        model_reset();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_pending_write();
        drain();
        test_zero_size();
        test_arbitration_order();
        test_random();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
